// File: rtl/dig_in_debounce.sv
// Per-channel switch debouncer: 2-FF synchronizer, shared sample-tick prescaler and a
// per-channel stability counter; emits clean levels plus one-cycle rise/fall pulses.
module dig_in_debounce #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 10,
    parameter logic        INIT         = 1'b0
) (
    input  logic             iCLK,
    input  logic             iRSTn,
    input  logic             iEN,
    input  logic [WIDTH-1:0] iRaw,
    output logic [WIDTH-1:0] oDOut,
    output logic [WIDTH-1:0] oRise,
    output logic [WIDTH-1:0] oFall,
    output logic             oChg,
    output logic             oTick
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CntW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

    typedef enum logic {StMatch, StPend} state_e;

    logic [WIDTH-1:0]           sync1_q, sync2_q;
    logic [PreW-1:0]            pre_q, pre_d;
    logic                       tick;
    state_e                     state_q [WIDTH];
    state_e                     state_d [WIDTH];
    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           dout_q, dout_d;
    logic [WIDTH-1:0]           rise_d, fall_d;
    logic [WIDTH-1:0]           rise_q, fall_q;
    logic                       chg_q, tick_q;
    logic                       mismatch;

    assign tick = iEN && (pre_q == PreLast);

    always_comb begin
        pre_d = pre_q;
        if (iEN) begin
            pre_d = tick ? '0 : pre_q + PreW'(1);
        end
    end

    always_comb begin
        mismatch = 1'b0;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            state_d[i] = state_q[i];
            mismatch   = sync2_q[i] ^ dout_q[i];
            unique case (state_q[i])
                StMatch: begin
                    cnt_d[i] = '0;
                    if (mismatch) begin
                        state_d[i] = StPend;
                        // The tick coinciding with the first mismatch already counts.
                        if (tick) begin
                            cnt_d[i] = CntW'(1);
                        end
                    end
                end
                StPend: begin
                    if (!mismatch) begin
                        cnt_d[i]   = '0;
                        state_d[i] = StMatch;
                    end else if (tick) begin
                        if (cnt_q[i] == CntLast) begin
                            dout_d[i]  = sync2_q[i];
                            rise_d[i]  = sync2_q[i];
                            fall_d[i]  = ~sync2_q[i];
                            cnt_d[i]   = '0;
                            state_d[i] = StMatch;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CntW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            sync1_q <= {WIDTH{INIT}};
            sync2_q <= {WIDTH{INIT}};
            pre_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= {WIDTH{INIT}};
            rise_q  <= '0;
            fall_q  <= '0;
            chg_q   <= 1'b0;
            tick_q  <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= StMatch;
            end
        end else begin
            sync1_q <= iRaw;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            chg_q   <= |(rise_d | fall_d);
            tick_q  <= tick;
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    assign oDOut = dout_q;
    assign oRise = rise_q;
    assign oFall = fall_q;
    assign oChg  = chg_q;
    assign oTick = tick_q;

endmodule

// File: tb/tb_dig_in_debounce.sv
// Bench for dig_in_debounce: tick-counting reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_dig_in_debounce;

    localparam int W  = 8;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic         en   = 1'b1;
    logic [W-1:0] raw  = 8'hFF;
    logic [W-1:0] dout, rise, fall;
    logic         chg, tick;

    int checks = 0;
    int errors = 0;

    dig_in_debounce #(
        .WIDTH       (W),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST),
        .INIT        (1'b0)
    ) dut (
        .iCLK (clk),
        .iRSTn(rstn),
        .iEN  (en),
        .iRaw (raw),
        .oDOut(dout),
        .oRise(rise),
        .oFall(fall),
        .oChg (chg),
        .oTick(tick)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once ST sample ticks have been seen while the
    // (two-cycle delayed) input continuously differs from the accepted level.
    bit [W-1:0] m_s1, m_s2, m_dout, m_rise, m_fall;
    bit         m_chg, m_tick, m_t, m_valid;
    int         m_pcnt;
    int         m_run [W];

    always @(posedge clk) begin
        if (!rstn) begin
            m_s1 = '0; m_s2 = '0; m_dout = '0; m_rise = '0; m_fall = '0;
            m_chg = 0; m_tick = 0; m_pcnt = 0; m_valid = 1;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_t = en && (m_pcnt == TD - 1);
            if (en) m_pcnt = m_t ? 0 : m_pcnt + 1;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] == m_dout[i]) m_run[i] = 0;
                else if (m_t) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == ST) begin
                        m_run[i]  = 0;
                        m_dout[i] = m_s2[i];
                        if (m_s2[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                    end
                end
            end
            m_chg  = |(m_rise | m_fall);
            m_tick = m_t;
            m_s2   = m_s1;
            m_s1   = raw;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("model_dout", dout, m_dout);
            cmp("model_rise", rise, m_rise);
            cmp("model_fall", fall, m_fall);
            cmp("model_chg",  chg,  m_chg);
            cmp("model_tick", tick, m_tick);
        end
    end

    int nt, first, found, ev, nr3, nf3, nfall, seen;

    initial begin
        // Reset with all inputs high
        repeat (3) @(negedge clk);
        cmp("rst_dout", dout, 8'h00);
        cmp("rst_rise", rise, 8'h00);
        cmp("rst_fall", fall, 8'h00);
        cmp("rst_chg",  chg,  1'b0);
        cmp("rst_tick", tick, 1'b0);
        rstn = 1'b1;
        raw  = 8'h00;
        nt = 0; first = -1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (tick) begin
                nt++;
                if (first < 0) first = j;
            end
        end
        cmp("tick_count", nt, 3);
        cmp("tick_first", first, 4);

        // Clean rising step on channel 0
        raw = 8'h01;
        found = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (found < 0 && dout[0]) begin
                found = j - 1;
                cmp("step_rise", rise, 8'h01);
                cmp("step_chg",  chg,  1'b1);
                cmp("step_fall", fall, 8'h00);
            end else if (found >= 0 && j == found + 2) begin
                cmp("step_rise_once", rise, 8'h00);
            end
        end
        cmp("step_latency", (found >= 10 && found <= 13), 1'b1);

        // Short glitch on channel 3 is rejected
        ev = 0;
        raw = 8'h09;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (rise != 0 || fall != 0 || chg) ev++;
        end
        raw = 8'h01;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (rise != 0 || fall != 0 || chg) ev++;
        end
        cmp("glitch_events", ev, 0);
        cmp("glitch_dout", dout, 8'h01);

        // Longer pulse on channel 3 is accepted, then released
        nr3 = 0; nf3 = 0;
        raw = 8'h09;
        for (int j = 0; j < 52; j++) begin
            @(negedge clk);
            if (j == 12) raw = 8'h01;
            if (rise[3]) nr3++;
            if (fall[3]) nf3++;
        end
        cmp("pulse12_rise3", nr3, 1);
        cmp("pulse12_fall3", nf3, 1);
        cmp("pulse12_dout", dout, 8'h01);

        // Multi-channel falling edge
        raw = 8'hFF;
        repeat (20) @(negedge clk);
        cmp("multi_high", dout, 8'hFF);
        raw = 8'h0F;
        nfall = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (fall != 0) begin
                nfall++;
                cmp("multi_fall", fall, 8'hF0);
                cmp("multi_dout", dout, 8'h0F);
                cmp("multi_chg",  chg,  1'b1);
                cmp("multi_rise", rise, 8'h00);
            end
        end
        cmp("multi_fall_count", nfall, 1);

        // Freeze with a change pending, then resume
        raw = 8'h00;
        repeat (6) @(negedge clk);
        en = 1'b0;
        nt = 0; ev = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (tick) nt++;
            if (chg) ev++;
        end
        cmp("freeze_ticks",  nt,   0);
        cmp("freeze_events", ev,   0);
        cmp("freeze_dout",   dout, 8'h0F);
        en = 1'b1;
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (fall != 0) begin
                seen++;
                cmp("resume_fall", fall, 8'h0F);
                cmp("resume_dout", dout, 8'h00);
            end
        end
        cmp("resume_seen", seen, 1);

        // Reset one tick before acceptance discards the pending change
        raw = 8'hFF;
        nt = 0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (tick && j >= 3) nt++;
            if (nt == 2) break;
        end
        cmp("midrst_ticks", nt, 2);
        cmp("midrst_pre_dout", dout, 8'h00);
        rstn = 1'b0;
        ev = 0;
        repeat (2) begin
            @(negedge clk);
            if (rise != 0 || chg) ev++;
        end
        raw  = 8'h00;
        rstn = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (rise != 0 || fall != 0 || chg) ev++;
        end
        cmp("midrst_events", ev, 0);
        cmp("midrst_dout", dout, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dig_in_debounce.md
Name: dig_in_debounce

Overview:
- Per-channel input conditioner that sits directly upstream of the digital input port peripheral. Its oDOut drives that port's 8-bit iDIn.
- Turns raw, bouncing switch/button levels into clean debounced levels, plus one-cycle rise/fall event pulses.
- Each channel has a 2-FF synchronizer, a shared sample-tick prescaler and a per-channel stability counter.
- A new level is accepted only after it has been held for STABLE_TICKS consecutive sample ticks.

Parameters:
- WIDTH, 8, number of input channels.
- TICK_DIV, 50000, clock cycles per sample tick (≥2). 50 MHz gives a 1 ms tick.
- STABLE_TICKS, 10, consecutive ticks a changed level must persist before acceptance (≥2).
- INIT, 0, reset value of every synchronizer stage and oDOut bit (all channels).

Ports:
- iCLK  input  1  system clock (MCLK); sole clock.
- iRSTn  input  1  synchronous, active-low reset, sampled on the iCLK rising edge.
- iEN  input  1  tick enable. When 0, the prescaler and counters freeze and oDOut holds.
- iRaw  input  WIDTH  raw asynchronous external inputs.
- oDOut  output  WIDTH  debounced levels (registered).
- oRise  output  WIDTH  one-cycle pulse per channel on an accepted 0→1 change.
- oFall  output  WIDTH  one-cycle pulse per channel on an accepted 1→0 change.
- oChg  output  1  OR of all oRise|oFall bits (registered, same cycle).
- oTick  output  1  prescaler tick strobe, for observation and test.

Behaviour:
- Reset (iRSTn=0 at a rising edge), all synchronously:
  - sync stages and oDOut = {WIDTH{INIT}};
  - prescaler = 0, all stability counters = 0;
  - oRise, oFall, oChg, oTick = 0.
- Reset asserted mid-count discards any pending change. No pulse is emitted for it.
- Synchronizer: s1<=iRaw, s2<=s1 every cycle, independent of iEN. Only s2 is used downstream.
- Prescaler:
  - Counts 0..TICK_DIV-1 while iEN=1.
  - Combinational tick = iEN & (count==TICK_DIV-1); count wraps to 0 on that cycle.
  - oTick is tick, registered: high for exactly one cycle per TICK_DIV cycles.
  - iEN=0 holds the count.
- Per-channel two-state FSM, MATCH / PEND:
  - MATCH: s2[i]==oDOut[i]; counter held at 0. s2[i]!=oDOut[i] → PEND. The counter is not yet incremented unless tick is high the same cycle.
  - PEND, s2[i]==oDOut[i] (glitch): counter ← 0, → MATCH, no output change.
  - PEND, mismatch persists and tick=1, counter<STABLE_TICKS-1: counter+1.
  - PEND, mismatch persists and tick=1, counter==STABLE_TICKS-1: oDOut[i] ← s2[i], counter ← 0, → MATCH, and on the same edge oRise[i] or oFall[i] ← 1 per direction.
- Event pulses:
  - Every oRise/oFall bit is 1 for exactly one cycle, otherwise 0.
  - The same edge updates oDOut, so the pulse and the new level appear together.
- Simultaneous channels:
  - Channels are fully independent. Several bits may pulse in the same cycle.
  - oChg is 1 whenever any bit pulses.
- Counter width: clog2(STABLE_TICKS). It never exceeds STABLE_TICKS-1; no wrap.
- Latency for a clean step on iRaw[i] (first sampled at edge E): oDOut[i] changes between edge E+(STABLE_TICKS-1)*TICK_DIV+2 and edge E+STABLE_TICKS*TICK_DIV+1, depending on prescaler phase.
- Glitch rejection: any mismatch lasting ≤(STABLE_TICKS-1)*TICK_DIV cycles never reaches oDOut and produces no pulse.
- The output interface is level-only. There is no handshake, and a downstream read never stalls this block.

Test Plan:
- Reset: TICK_DIV=4, STABLE_TICKS=3, INIT=0. Hold iRSTn=0 for 3 cycles with iRaw=8'hFF → oDOut=8'h00, oRise=oFall=0, oChg=0. Then oTick pulses every 4th cycle after release.
- Clean step: iRaw 8'h00→8'h01, held → oDOut=8'h01 within edges E+10..E+13. oRise=8'h01 and oChg=1 for exactly one cycle, coincident with the oDOut change. oFall stays 0.
- Glitch: iRaw[3] high for 8 cycles, then low → oDOut[3] stays 0, and oRise/oFall/oChg stay 0 throughout. Repeat the pulse at 12 cycles → accepted, one oRise[3].
- Multi-channel/fall: from oDOut=8'hFF, set iRaw=8'h0F → oDOut=8'h0F and oFall=8'hF0 in the same single cycle, oChg=1.
- Freeze and mid-operation reset:
  - Drop iEN with a change pending → oDOut holds and oTick=0. Raise iEN → acceptance resumes.
  - Assert iRSTn=0 one tick before acceptance → oDOut returns to 8'h00 with no pulse.
